// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination scoreboard for a short in-order
// pipeline. Tracks DEPTH stages after ID (entry 0 = EX, entry DEPTH-1 = oldest),
// raises Hazard_Detected to freeze IF/ID, and selects forwarding sources.
// Optional feature macro: HAZARD_SCOREBOARD_FORWARDING_EN
//   defined   -> only load-use on entry 0 stalls; fwd_selN picks the youngest match
//   undefined -> any RAW match stalls; fwd_selN tied to 0
module hazard_scoreboard #(
    parameter int ADDRESS_LEN_REG_FILE = 4,
    parameter int DEPTH                = 2,
    parameter int CNT_LEN              = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] src1,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] src2,
    input  logic                            Two_src,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
    input  logic                            WB_EN,
    input  logic                            MEM_R_EN,
    input  logic                            flush,
    input  logic                            stall_ext,
    output logic                            Hazard_Detected,
    output logic                            issued,
    output logic [3:0]                      fwd_sel1,
    output logic [3:0]                      fwd_sel2,
    output logic [3:0]                      occupancy,
    output logic [CNT_LEN-1:0]              stall_cnt
);

    typedef struct packed {
        logic                            valid;
        logic [ADDRESS_LEN_REG_FILE-1:0] dest;
        logic                            wb_en;
        logic                            mem_r_en;
    } entry_t;

    entry_t             entry_r      [DEPTH];
    entry_t             entry_next_s [DEPTH];
    logic [3:0]         occ_r;
    logic [3:0]         occ_next_s;
    logic [CNT_LEN-1:0] cnt_r;
    logic [CNT_LEN-1:0] cnt_next_s;

    // sel = 0 means no match, k means entry k-1 is the youngest match
    logic [3:0] sel1_s;
    logic [3:0] sel2_s;
    logic       use2_s;
    logic       load_use_s;
    logic       raw_hazard_s;
    logic       hazard_s;
    logic       issued_s;

    // Youngest matching entry per source: scan oldest to youngest so the
    // lowest index overwrites any older match.
    always_comb begin
        sel1_s = 4'd0;
        sel2_s = 4'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_r[i].valid && entry_r[i].wb_en && (entry_r[i].dest == src1)) begin
                sel1_s = 4'(i + 1);
            end else begin
                sel1_s = sel1_s;
            end
            if (entry_r[i].valid && entry_r[i].wb_en && (entry_r[i].dest == src2)) begin
                sel2_s = 4'(i + 1);
            end else begin
                sel2_s = sel2_s;
            end
        end
    end

    assign use2_s = Two_src;

    // Load-use: a used source whose youngest producer is a load still in EX.
    assign load_use_s = entry_r[0].mem_r_en &&
                        ((sel1_s == 4'd1) || (use2_s && (sel2_s == 4'd1)));

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    assign raw_hazard_s = load_use_s;
`else
    // Any in-flight producer stalls; load-use is a subset and changes nothing.
    assign raw_hazard_s = (sel1_s != 4'd0) || (use2_s && (sel2_s != 4'd0)) || load_use_s;
`endif

    // Flush squashes the ID instruction, so it overrides any hazard.
    assign hazard_s = rst && issue_valid && !flush && raw_hazard_s;
    assign issued_s = rst && issue_valid && !hazard_s && !flush && !stall_ext;

    assign Hazard_Detected = hazard_s;
    assign issued          = issued_s;

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    assign fwd_sel1 = rst ? sel1_s : 4'd0;
    assign fwd_sel2 = (rst && use2_s) ? sel2_s : 4'd0;
`else
    assign fwd_sel1 = 4'd0;
    assign fwd_sel2 = 4'd0;
`endif

    // Next entry contents: shift toward the oldest slot, load ID or a bubble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_next_s[i] = entry_r[i];
        end
        if (stall_ext) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_next_s[i] = entry_r[i];
            end
        end else begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                entry_next_s[i] = entry_r[i - 1];
            end
            if (issued_s) begin
                entry_next_s[0].valid    = 1'b1;
                entry_next_s[0].dest     = Dest;
                entry_next_s[0].wb_en    = WB_EN;
                entry_next_s[0].mem_r_en = MEM_R_EN;
            end else begin
                entry_next_s[0] = '0;
            end
        end
    end

    // Occupancy computed from the next entries so the register tracks them with no lag.
    always_comb begin
        occ_next_s = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next_s = occ_next_s +
                         {3'd0, (entry_next_s[i].valid && entry_next_s[i].wb_en)};
        end
    end

    // Saturating stall counter; holds during external freeze.
    always_comb begin
        cnt_next_s = cnt_r;
        if (stall_ext) begin
            cnt_next_s = cnt_r;
        end else if (hazard_s && (cnt_r != {CNT_LEN{1'b1}})) begin
            cnt_next_s = cnt_r + {{(CNT_LEN-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            occ_r <= 4'd0;
            cnt_r <= {CNT_LEN{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_next_s[i];
            end
            occ_r <= occ_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign occupancy = occ_r;
    assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=2, CNT_LEN=2). Expected values
// follow the build mode selected by HAZARD_SCOREBOARD_FORWARDING_EN.
module tb_hazard_scoreboard;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       Two_src;
    logic [3:0] Dest;
    logic       WB_EN;
    logic       MEM_R_EN;
    logic       flush;
    logic       stall_ext;
    logic       Hazard_Detected;
    logic       issued;
    logic [3:0] fwd_sel1;
    logic [3:0] fwd_sel2;
    logic [3:0] occupancy;
    logic [1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    hazard_scoreboard #(
        .ADDRESS_LEN_REG_FILE(4),
        .DEPTH(2),
        .CNT_LEN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .src1(src1),
        .src2(src2),
        .Two_src(Two_src),
        .Dest(Dest),
        .WB_EN(WB_EN),
        .MEM_R_EN(MEM_R_EN),
        .flush(flush),
        .stall_ext(stall_ext),
        .Hazard_Detected(Hazard_Detected),
        .issued(issued),
        .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic       r, iv;
        logic [3:0] s1, s2;
        logic       two;
        logic [3:0] d;
        logic       wb, mr, fl, se;
        logic       haz, iss;
        logic [3:0] f1, f2, occ;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, iv, input logic [3:0] s1, s2,
                                input logic two, input logic [3:0] d,
                                input logic wb, mr, fl, se, haz, iss,
                                input logic [3:0] f1, f2, occ, input logic [1:0] cnt);
        vec_t v;
        v.r = r; v.iv = iv; v.s1 = s1; v.s2 = s2; v.two = two; v.d = d;
        v.wb = wb; v.mr = mr; v.fl = fl; v.se = se; v.haz = haz; v.iss = iss;
        v.f1 = f1; v.f2 = f2; v.occ = occ; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.r; issue_valid = v.iv; src1 = v.s1; src2 = v.s2; Two_src = v.two;
        Dest = v.d; WB_EN = v.wb; MEM_R_EN = v.mr; flush = v.fl; stall_ext = v.se;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic idle(input logic r);
        vec_t v;
        v = mk(r, L, 4'd0, 4'd0, L, 4'd0, L, L, L, L, L, L, 4'd0, 4'd0, 4'd0, 2'd0);
        drive(v);
    endtask

    // rst iv s1 s2 two dest wb mr fl se | haz iss f1 f2 occ cnt
    task automatic fill_table();
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        vecs.push_back(mk(L,H,4'd3,4'd0,L,4'd1,H,L,L,L, L,L,4'd0,4'd0,4'd0,2'd0)); // in reset
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd5,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0)); // ALU dest5
        vecs.push_back(mk(H,H,4'd0,4'd5,H,4'd0,L,L,L,L, L,H,4'd0,4'd1,4'd1,2'd0)); // fwd from EX
        vecs.push_back(mk(H,H,4'd0,4'd5,H,4'd0,L,L,L,L, L,H,4'd0,4'd2,4'd1,2'd0)); // fwd from entry 1
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd8,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0));
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd8,H,L,L,L, L,H,4'd0,4'd0,4'd1,2'd0)); // wb_en=0 no match
        vecs.push_back(mk(H,H,4'd8,4'd8,H,4'd0,L,L,L,L, L,H,4'd1,4'd1,4'd2,2'd0)); // youngest wins
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd7,H,H,L,L, L,H,4'd0,4'd0,4'd1,2'd0)); // load dest7
        vecs.push_back(mk(H,H,4'd7,4'd0,L,4'd0,L,L,L,L, H,L,4'd1,4'd0,4'd1,2'd0)); // load-use stall
        vecs.push_back(mk(H,H,4'd7,4'd0,L,4'd0,L,L,L,L, L,H,4'd2,4'd0,4'd1,2'd1)); // then forward
        vecs.push_back(mk(H,H,4'd1,4'd0,L,4'd3,H,H,L,L, L,H,4'd0,4'd0,4'd0,2'd1)); // load dest3
        vecs.push_back(mk(H,H,4'd3,4'd0,L,4'd0,L,L,H,L, L,L,4'd1,4'd0,4'd1,2'd1)); // flush beats hazard
        vecs.push_back(mk(H,L,4'd3,4'd0,L,4'd0,L,L,L,L, L,L,4'd2,4'd0,4'd1,2'd1));
        vecs.push_back(mk(H,L,4'd0,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd0,2'd1)); // drained
`else
        vecs.push_back(mk(L,H,4'd3,4'd0,L,4'd1,H,L,L,L, L,L,4'd0,4'd0,4'd0,2'd0)); // in reset
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd3,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0)); // dest3
        vecs.push_back(mk(H,H,4'd3,4'd0,L,4'd4,H,L,L,L, H,L,4'd0,4'd0,4'd1,2'd0)); // stall 1
        vecs.push_back(mk(H,H,4'd3,4'd0,L,4'd4,H,L,L,L, H,L,4'd0,4'd0,4'd1,2'd1)); // stall 2
        vecs.push_back(mk(H,H,4'd3,4'd0,L,4'd4,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd2)); // issues
        vecs.push_back(mk(H,H,4'd1,4'd4,L,4'd5,L,L,L,L, L,H,4'd0,4'd0,4'd1,2'd2)); // src2 unused
        vecs.push_back(mk(H,H,4'd1,4'd4,H,4'd6,H,L,L,L, H,L,4'd0,4'd0,4'd1,2'd2)); // src2 used
        vecs.push_back(mk(H,H,4'd5,4'd4,H,4'd6,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd3)); // wb_en=0 ignored
        vecs.push_back(mk(H,H,4'd6,4'd0,L,4'd0,L,L,L,L, H,L,4'd0,4'd0,4'd1,2'd3)); // counter at max
        vecs.push_back(mk(H,H,4'd6,4'd0,L,4'd0,L,L,H,L, L,L,4'd0,4'd0,4'd1,2'd3)); // flush + hazard
        vecs.push_back(mk(H,L,4'd6,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd0,2'd3)); // saturated, drained
        vecs.push_back(mk(L,L,4'd0,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd0,2'd3)); // reset clears cnt
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd1,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0));
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd2,H,L,L,L, L,H,4'd0,4'd0,4'd1,2'd0));
        vecs.push_back(mk(H,H,4'd2,4'd0,L,4'd9,H,L,L,H, H,L,4'd0,4'd0,4'd2,2'd0)); // freeze 1
        vecs.push_back(mk(H,H,4'd2,4'd0,L,4'd9,H,L,L,H, H,L,4'd0,4'd0,4'd2,2'd0)); // freeze 2
        vecs.push_back(mk(H,H,4'd2,4'd0,L,4'd9,H,L,L,H, H,L,4'd0,4'd0,4'd2,2'd0)); // freeze 3
        vecs.push_back(mk(H,L,4'd0,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd2,2'd0)); // released
        vecs.push_back(mk(H,L,4'd0,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd1,2'd0)); // shifting
        vecs.push_back(mk(H,L,4'd0,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd0,2'd0));
        vecs.push_back(mk(H,H,4'd0,4'd0,L,4'd7,H,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0));
        vecs.push_back(mk(H,H,4'd7,4'd0,L,4'd0,L,L,L,L, H,L,4'd0,4'd0,4'd1,2'd0)); // hazard
        vecs.push_back(mk(L,H,4'd7,4'd0,L,4'd0,L,L,L,L, L,L,4'd0,4'd0,4'd1,2'd1)); // reset mid-hazard
        vecs.push_back(mk(H,H,4'd7,4'd0,L,4'd0,L,L,L,L, L,H,4'd0,4'd0,4'd0,2'd0)); // empty after
`endif
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            n_vec++;
            if (Hazard_Detected !== vecs[i].haz || issued !== vecs[i].iss ||
                fwd_sel1 !== vecs[i].f1 || fwd_sel2 !== vecs[i].f2 ||
                occupancy !== vecs[i].occ || stall_cnt !== vecs[i].cnt) begin
                n_bad++;
                $display("FAIL vec%0d: got haz=%b iss=%b f1=%0d f2=%0d occ=%0d cnt=%0d, expected haz=%b iss=%b f1=%0d f2=%0d occ=%0d cnt=%0d",
                         i, Hazard_Detected, issued, fwd_sel1, fwd_sel2, occupancy, stall_cnt,
                         vecs[i].haz, vecs[i].iss, vecs[i].f1, vecs[i].f2, vecs[i].occ, vecs[i].cnt);
            end
        end
    endtask

    // Reset asserted while frozen with a pending dependency.
    task automatic seq_reset_mid_stall();
        int exp_haz;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        exp_haz = 0;
`else
        exp_haz = 1;
`endif
        @(negedge clk); idle(L);
        @(negedge clk); idle(H);
        issue_valid = H; Dest = 4'd1; WB_EN = H;
        @(negedge clk);
        Dest = 4'd0; WB_EN = L; src1 = 4'd1; stall_ext = H;
        #1;
        chk("frozen_hazard", int'(Hazard_Detected), exp_haz);
        chk("frozen_issued", int'(issued), 0);
        @(negedge clk);
        rst = L;
        #1;
        chk("rst_hazard", int'(Hazard_Detected), 0);
        chk("rst_occ_before_edge", int'(occupancy), 1);
        @(negedge clk);
        rst = H; stall_ext = L;
        #1;
        chk("post_rst_occ", int'(occupancy), 0);
        chk("post_rst_hazard", int'(Hazard_Detected), 0);
        chk("post_rst_issued", int'(issued), 1);
    endtask

    // Dependent consumer after a load: bounded wait for issue.
    task automatic seq_wait_issue();
        int stalls;
        int exp_stalls;
        int exp_fwd;
        logic done;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        exp_stalls = 1; exp_fwd = 2;
`else
        exp_stalls = 2; exp_fwd = 0;
`endif
        stalls = 0;
        done = L;
        @(negedge clk); idle(L);
        @(negedge clk); idle(H);
        issue_valid = H; Dest = 4'd6; WB_EN = H; MEM_R_EN = H;
        @(negedge clk);
        Dest = 4'd0; WB_EN = L; MEM_R_EN = L; src1 = 4'd6;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (issued) begin
                done = H;
                break;
            end
            if (Hazard_Detected) stalls++;
            @(negedge clk);
            #1;
        end
        chk("issue_within_bound", int'(done), 1);
        chk("stall_cycles", stalls, exp_stalls);
        chk("stall_cnt_at_issue", int'(stall_cnt), exp_stalls);
        chk("fwd_sel1_at_issue", int'(fwd_sel1), exp_fwd);
    endtask

    initial begin
        idle(L);
        repeat (2) @(negedge clk);
        fill_table();
        run_table();
        seq_reset_mid_stall();
        seq_wait_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
